vga_timing_ctrl: RTL and testbench

Upstream stage of the character-terminal display path. Generates the pixel-rate tick and the horizontal and vertical scan counters (h_ctr, v_ctr) that the display block consumes. Takes the display block's pixel_on result back and produces the VGA pins (hsync, vsync, 12-bit RGB). A latency-matching delay line keeps sync and blanking aligned with the pipelined pixel_on.

---
 rtl/vga_timing_pkg.sv | 35 +++
 rtl/vga_timing_ctrl_pix_tick_div.sv | 31 +++
 rtl/vga_timing_ctrl.sv | 143 ++++++++++++++
 tb/tb_vga_timing_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared timing defaults (640x480@60), derived totals, colour widths and
// the scan-flag payload carried through the sync/blank delay line.
package vga_timing_pkg;

    localparam int unsigned CLK_DIV_DEF  = 4;
    localparam int unsigned PIX_LAT_DEF  = 2;

    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned H_FP_DEF     = 16;
    localparam int unsigned H_SYNC_DEF   = 96;
    localparam int unsigned H_BP_DEF     = 48;
    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned V_FP_DEF     = 10;
    localparam int unsigned V_SYNC_DEF   = 2;
    localparam int unsigned V_BP_DEF     = 33;

    localparam int unsigned H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int unsigned V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    localparam int unsigned CTR_W        = 11;
    localparam int unsigned RGB_W        = 4;
    localparam int unsigned COLOR_W      = 3 * RGB_W;

    localparam logic [COLOR_W-1:0] BLANK_COLOR = 12'h000;

    // Decoded scan state, all flags active-high regardless of pin polarity.
    typedef struct packed {
        logic active;
        logic hs;
        logic vs;
    } scan_flags_t;

    localparam scan_flags_t SCAN_IDLE = '{active: 1'b0, hs: 1'b0, vs: 1'b0};

endpackage

// File: rtl/vga_timing_ctrl_pix_tick_div.sv
// Clock divider producing a registered one-clk pixel strobe every CLK_DIV clks.
module pix_tick_div #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic pix_tick,
    output logic tick_pre_c
);

    localparam int unsigned DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'(CLK_DIV - 2);

    logic [DIV_W-1:0] div;

    // High in the clk before div reaches its last value, so the registered
    // strobe lines up exactly with div == CLK_DIV-1.
    assign tick_pre_c = (div == DIV_PRE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div      <= '0;
            pix_tick <= 1'b0;
        end else begin
            div      <= (div == DIV_LAST) ? '0 : div + DIV_W'(1);
            pix_tick <= tick_pre_c;
        end
    end

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA scan timing: pixel tick, h/v counters, sync/blank decode with a
// latency-matching delay line, colour latch and registered output pins.
module vga_timing_ctrl
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV      = CLK_DIV_DEF,
    parameter int unsigned H_ACTIVE     = H_ACTIVE_DEF,
    parameter int unsigned H_FP         = H_FP_DEF,
    parameter int unsigned H_SYNC       = H_SYNC_DEF,
    parameter int unsigned H_BP         = H_BP_DEF,
    parameter int unsigned V_ACTIVE     = V_ACTIVE_DEF,
    parameter int unsigned V_FP         = V_FP_DEF,
    parameter int unsigned V_SYNC       = V_SYNC_DEF,
    parameter int unsigned V_BP         = V_BP_DEF,
    parameter int unsigned PIX_LAT      = PIX_LAT_DEF,
    parameter bit          SYNC_ACT_LOW = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pixel_on,
    input  logic [COLOR_W-1:0]  fg_color,
    input  logic [COLOR_W-1:0]  bg_color,
    output logic [CTR_W-1:0]    h_ctr,
    output logic [CTR_W-1:0]    v_ctr,
    output logic                pix_tick,
    output logic                frame_start,
    output logic                vga_hsync,
    output logic                vga_vsync,
    output logic [RGB_W-1:0]    vga_r,
    output logic [RGB_W-1:0]    vga_g,
    output logic [RGB_W-1:0]    vga_b
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CTR_W-1:0] H_LAST     = CTR_W'(H_TOTAL - 1);
    localparam logic [CTR_W-1:0] V_LAST     = CTR_W'(V_TOTAL - 1);
    localparam logic [CTR_W-1:0] H_ACT_END  = CTR_W'(H_ACTIVE);
    localparam logic [CTR_W-1:0] V_ACT_END  = CTR_W'(V_ACTIVE);
    localparam logic [CTR_W-1:0] HS_START   = CTR_W'(H_ACTIVE + H_FP);
    localparam logic [CTR_W-1:0] HS_END     = CTR_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CTR_W-1:0] VS_START   = CTR_W'(V_ACTIVE + V_FP);
    localparam logic [CTR_W-1:0] VS_END     = CTR_W'(V_ACTIVE + V_FP + V_SYNC);

    logic               tick_pre_c;
    logic [COLOR_W-1:0] fg_latched;
    logic [COLOR_W-1:0] bg_latched;
    logic [COLOR_W-1:0] rgb;
    scan_flags_t        raw_c;
    scan_flags_t        dly_c;

    pix_tick_div #(
        .CLK_DIV    (CLK_DIV)
    ) u_div (
        .clk        (clk),
        .rst        (rst),
        .pix_tick   (pix_tick),
        .tick_pre_c (tick_pre_c)
    );

    // Scan counters, advanced once per pixel tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_ctr <= '0;
            v_ctr <= '0;
        end else if (pix_tick) begin
            if (h_ctr == H_LAST) begin
                h_ctr <= '0;
                v_ctr <= (v_ctr == V_LAST) ? '0 : v_ctr + CTR_W'(1);
            end else begin
                h_ctr <= h_ctr + CTR_W'(1);
            end
        end
    end

    // Counters are stable through the pre-tick clk, so (0,0) here marks the frame tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= tick_pre_c && (h_ctr == '0) && (v_ctr == '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fg_latched <= '0;
            bg_latched <= '0;
        end else if (frame_start) begin
            fg_latched <= fg_color;
            bg_latched <= bg_color;
        end
    end

    always_comb begin
        raw_c        = SCAN_IDLE;
        raw_c.active = (h_ctr < H_ACT_END) && (v_ctr < V_ACT_END);
        raw_c.hs     = (h_ctr >= HS_START) && (h_ctr < HS_END);
        raw_c.vs     = (v_ctr >= VS_START) && (v_ctr < VS_END);
    end

    generate
        if (PIX_LAT == 0) begin : g_direct
            assign dly_c = raw_c;
        end else begin : g_dly
            scan_flags_t dl [PIX_LAT];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < int'(PIX_LAT); i++) begin
                        dl[i] <= SCAN_IDLE;
                    end
                end else if (pix_tick) begin
                    dl[0] <= raw_c;
                    for (int i = 1; i < int'(PIX_LAT); i++) begin
                        dl[i] <= dl[i-1];
                    end
                end
            end

            assign dly_c = dl[PIX_LAT-1];
        end
    endgenerate

    // Output stage adds the final tick of latency shared by sync and colour.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb       <= BLANK_COLOR;
            vga_hsync <= SYNC_ACT_LOW;
            vga_vsync <= SYNC_ACT_LOW;
        end else if (pix_tick) begin
            rgb       <= dly_c.active ? (pixel_on ? fg_latched : bg_latched) : BLANK_COLOR;
            vga_hsync <= dly_c.hs ^ SYNC_ACT_LOW;
            vga_vsync <= dly_c.vs ^ SYNC_ACT_LOW;
        end
    end

    assign vga_r = rgb[3*RGB_W-1:2*RGB_W];
    assign vga_g = rgb[2*RGB_W-1:RGB_W];
    assign vga_b = rgb[RGB_W-1:0];

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Randomized bench for vga_timing_ctrl on a reduced raster, checked every clk
// against a tick-index reference model of the scan and pin timing.
module tb_vga_timing_ctrl;

    localparam int CLK_DIV = 4;
    localparam int PIX_LAT = 2;
    localparam int HA = 8, HF = 2, HS = 3, HB = 2;
    localparam int VA = 4, VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int LAT = PIX_LAT + 1;

    logic        clk;
    logic        rst;
    logic        pixel_on;
    logic [11:0] fg_color;
    logic [11:0] bg_color;
    logic [10:0] h_ctr;
    logic [10:0] v_ctr;
    logic        pix_tick;
    logic        frame_start;
    logic        vga_hsync;
    logic        vga_vsync;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;

    vga_timing_ctrl #(
        .CLK_DIV      (CLK_DIV),
        .H_ACTIVE     (HA),
        .H_FP         (HF),
        .H_SYNC       (HS),
        .H_BP         (HB),
        .V_ACTIVE     (VA),
        .V_FP         (VF),
        .V_SYNC       (VS),
        .V_BP         (VB),
        .PIX_LAT      (PIX_LAT),
        .SYNC_ACT_LOW (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pixel_on    (pixel_on),
        .fg_color    (fg_color),
        .bg_color    (bg_color),
        .h_ctr       (h_ctr),
        .v_ctr       (v_ctr),
        .pix_tick    (pix_tick),
        .frame_start (frame_start),
        .vga_hsync   (vga_hsync),
        .vga_vsync   (vga_vsync),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: clks since reset release, latched colours, expected pins.
    int          cyc;
    logic [11:0] fg_m, bg_m;
    logic [11:0] e_rgb;
    logic        e_hs, e_vs;
    bit          rand_colors;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t cyc=%0d", tag, got, exp, $time, cyc);
        end
    endtask

    task automatic model_reset();
        cyc   = 0;
        fg_m  = 12'h000;
        bg_m  = 12'h000;
        e_rgb = 12'h000;
        e_hs  = 1'b1;
        e_vs  = 1'b1;
    endtask

    task automatic check_all();
        int p;
        p = cyc / CLK_DIV;
        check("h_ctr", 32'(h_ctr), 32'(p % HT));
        check("v_ctr", 32'(v_ctr), 32'((p / HT) % VT));
        check("pix_tick", 32'(pix_tick), 32'(cyc % CLK_DIV == CLK_DIV - 1));
        check("frame_start", 32'(frame_start),
              32'((cyc % CLK_DIV == CLK_DIV - 1) && (p % FRAME == 0)));
        check("hsync", 32'(vga_hsync), 32'(e_hs));
        check("vsync", 32'(vga_vsync), 32'(e_vs));
        check("rgb", 32'({vga_r, vga_g, vga_b}), 32'(e_rgb));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_h"},     32'(h_ctr), 32'(0));
        check({tag, "_v"},     32'(v_ctr), 32'(0));
        check({tag, "_tick"},  32'(pix_tick), 32'(0));
        check({tag, "_frame"}, 32'(frame_start), 32'(0));
        check({tag, "_hs"},    32'(vga_hsync), 32'(1));
        check({tag, "_vs"},    32'(vga_vsync), 32'(1));
        check({tag, "_rgb"},   32'({vga_r, vga_g, vga_b}), 32'(0));
    endtask

    // One clk: advance model, compare every output, then drive fresh inputs.
    task automatic step();
        int p, q, h, v;
        @(posedge clk);
        #1;
        cyc++;
        if (cyc % CLK_DIV == 0) begin
            p = cyc / CLK_DIV;
            q = p - LAT;
            if (q >= 0) begin
                h     = q % HT;
                v     = (q / HT) % VT;
                e_rgb = (h < HA && v < VA) ? (pixel_on ? fg_m : bg_m) : 12'h000;
                e_hs  = !(h >= HA + HF && h < HA + HF + HS);
                e_vs  = !(v >= VA + VF && v < VA + VF + VS);
            end
            if ((p - 1) % FRAME == 0) begin
                fg_m = fg_color;
                bg_m = bg_color;
            end
        end
        check_all();
        pixel_on = 1'($urandom_range(0, 1));
        if (rand_colors && $urandom_range(0, 63) == 0) fg_color = 12'($urandom);
        if (rand_colors && $urandom_range(0, 63) == 0) bg_color = 12'($urandom);
    endtask

    initial begin
        rst         = 1'b1;
        pixel_on    = 1'b0;
        fg_color    = 12'hF00;
        bg_color    = 12'h00F;
        rand_colors = 1'b0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        @(negedge clk);
        rst = 1'b0;
        check_reset_state("release");

        // Directed colours; fg changes mid-frame 0 and must appear from frame 1.
        for (int i = 0; i < 3 * FRAME * CLK_DIV; i++) begin
            step();
            if (cyc == (2 * HT + 5) * CLK_DIV) fg_color = 12'h0F0;
        end

        // Land mid-line inside the active region, then reset between edges.
        for (int i = 0; i < HT * CLK_DIV; i++) begin
            if (((cyc / CLK_DIV) % HT == 6) && (cyc % CLK_DIV == 1)) break;
            step();
        end
        #2;
        rst = 1'b1;
        #1;
        check_reset_state("async");
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("held");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_reset_state("rerelease");

        rand_colors = 1'b1;
        for (int i = 0; i < 3 * FRAME * CLK_DIV; i++) begin
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
